// File: rtl/grf_wb_arbiter_pkg.sv
// rtl/grf_wb_arbiter_pkg.sv - shared constants for the GRF write-back arbiter
package grf_wb_arbiter_pkg;

    localparam int REG_AW           = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;
    localparam int NUM_REGS         = 32;
    localparam int MAX_WAIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_MDU  = 2'd2
    } grant_t;

endpackage

// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - pending-destination scoreboard and decode hazard stall
module grf_scoreboard
    import grf_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                res,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_a3,
    input  logic                iss_long,
    input  logic [REG_AW-1:0]   rd_a1,
    input  logic [REG_AW-1:0]   rd_a2,
    input  logic                mdu_xfer,
    input  logic [REG_AW-1:0]   mdu_a3,
    input  logic                pipe_hold,
    output logic                stall,
    output logic [NUM_REGS-1:0] pend
);

    logic [NUM_REGS-1:0] clr_now;
    logic [NUM_REGS-1:0] set_now;
    logic [NUM_REGS-1:0] eff;
    logic [NUM_REGS-1:0] pend_nxt;

    always_comb begin
        clr_now = '0;
        set_now = '0;
        if (mdu_xfer)
            clr_now = NUM_REGS'(1) << mdu_a3;
        if (iss_valid && iss_long && iss_a3 != ZERO_REG && !stall)
            set_now = NUM_REGS'(1) << iss_a3;
        eff = pend & ~clr_now;
        // Set is OR'd after the clear so a same-cycle reissue keeps the register pending.
        pend_nxt = eff | set_now;
        pend_nxt[0] = 1'b0;
    end

    always_comb begin
        stall = 1'b0;
        if (res)
            stall = 1'b1;
        else if ((rd_a1 != ZERO_REG && eff[rd_a1]) ||
                 (rd_a2 != ZERO_REG && eff[rd_a2]) ||
                 (iss_valid && iss_a3 != ZERO_REG && eff[iss_a3]) ||
                 pipe_hold)
            stall = 1'b1;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res)
            pend <= '0;
        else
            pend <= pend_nxt;
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - shares the GRF write port between W stage and MDU
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                clk,
    input  logic                res,
    input  logic                pipe_we,
    input  logic [REG_AW-1:0]   pipe_a3,
    input  logic [31:0]         pipe_wd,
    output logic                pipe_hold,
    input  logic                mdu_valid,
    input  logic [REG_AW-1:0]   mdu_a3,
    input  logic [31:0]         mdu_wd,
    output logic                mdu_ready,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_a3,
    input  logic                iss_long,
    input  logic [REG_AW-1:0]   rd_a1,
    input  logic [REG_AW-1:0]   rd_a2,
    output logic                stall,
    output logic                grf_we,
    output logic [REG_AW-1:0]   grf_a3,
    output logic [31:0]         grf_wd,
    output logic [NUM_REGS-1:0] pend
);

    logic [3:0] starve_cnt;
    logic       p_req;
    logic       m_req;
    grant_t     gnt;

    assign p_req = pipe_we && (pipe_a3 != ZERO_REG);
    assign m_req = mdu_valid;

    always_comb begin
        gnt = GNT_NONE;
        if (!res) begin
            if (starve_cnt == 4'(MAX_WAIT) && m_req)
                gnt = GNT_MDU;
            else if (p_req)
                gnt = GNT_PIPE;
            else if (m_req)
                gnt = GNT_MDU;
        end
    end

    always_comb begin
        grf_we    = 1'b0;
        grf_a3    = ZERO_REG;
        grf_wd    = '0;
        mdu_ready = 1'b0;
        pipe_hold = 1'b0;
        case (gnt)
            GNT_PIPE: begin
                grf_we = 1'b1;
                grf_a3 = pipe_a3;
                grf_wd = pipe_wd;
            end
            GNT_MDU: begin
                mdu_ready = 1'b1;
                pipe_hold = p_req;
                grf_we    = (mdu_a3 != ZERO_REG);
                grf_a3    = mdu_a3;
                grf_wd    = mdu_wd;
            end
            default: ;
        endcase
    end

    // Counts consecutive refusals of a waiting MDU result; saturates at MAX_WAIT.
    always_ff @(posedge clk or posedge res) begin
        if (res)
            starve_cnt <= '0;
        else if (mdu_ready || !mdu_valid)
            starve_cnt <= '0;
        else if (starve_cnt != 4'(MAX_WAIT))
            starve_cnt <= starve_cnt + 4'd1;
    end

    grf_scoreboard u_sb (
        .clk       (clk),
        .res       (res),
        .iss_valid (iss_valid),
        .iss_a3    (iss_a3),
        .iss_long  (iss_long),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .mdu_xfer  (mdu_ready),
        .mdu_a3    (mdu_a3),
        .pipe_hold (pipe_hold),
        .stall     (stall),
        .pend      (pend)
    );

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed self-checking bench for grf_wb_arbiter
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        res;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic        pipe_hold;
    logic        mdu_valid;
    logic [4:0]  mdu_a3;
    logic [31:0] mdu_wd;
    logic        mdu_ready;
    logic        iss_valid;
    logic [4:0]  iss_a3;
    logic        iss_long;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic        stall;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] pend;

    int checks = 0;
    int errors = 0;

    grf_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .res(res),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_hold(pipe_hold),
        .mdu_valid(mdu_valid), .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
        .iss_valid(iss_valid), .iss_a3(iss_a3), .iss_long(iss_long),
        .rd_a1(rd_a1), .rd_a2(rd_a2), .stall(stall),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pipe_we = 0; pipe_a3 = 0; pipe_wd = 0;
        mdu_valid = 0; mdu_a3 = 0; mdu_wd = 0;
        iss_valid = 0; iss_a3 = 0; iss_long = 0;
        rd_a1 = 0; rd_a2 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b1;
        idle();
        step();
        step();
        chk("rst_pend", pend, 32'h0);
        chk("rst_we", {31'b0, grf_we}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h1);
        chk("rst_ready", {31'b0, mdu_ready}, 32'h0);
        chk("rst_hold", {31'b0, pipe_hold}, 32'h0);
        res = 1'b0;
        #1;
        chk("rst_release_stall", {31'b0, stall}, 32'h0);

        // async reset mid-cycle with $2 pending
        step();
        iss_valid = 1; iss_long = 1; iss_a3 = 5'd2;
        step();
        idle();
        chk("pend_2", pend, 32'h0000_0004);
        #2;
        res = 1'b1;
        #1;
        chk("async_pend", pend, 32'h0);
        chk("async_we", {31'b0, grf_we}, 32'h0);
        chk("async_stall", {31'b0, stall}, 32'h1);
        res = 1'b0;
        #1;
        chk("async_release", {31'b0, stall}, 32'h0);

        // RAW on $4, released by same-cycle MDU writeback
        step();
        iss_valid = 1; iss_long = 1; iss_a3 = 5'd4;
        step();
        idle();
        rd_a1 = 5'd4;
        #1;
        chk("raw_pend", pend, 32'h0000_0010);
        chk("raw_stall", {31'b0, stall}, 32'h1);
        mdu_valid = 1; mdu_a3 = 5'd4; mdu_wd = 32'h1234;
        #1;
        chk("wb_stall", {31'b0, stall}, 32'h0);
        chk("wb_we", {31'b0, grf_we}, 32'h1);
        chk("wb_a3", {27'b0, grf_a3}, 32'd4);
        chk("wb_wd", grf_wd, 32'h1234);
        chk("wb_ready", {31'b0, mdu_ready}, 32'h1);
        step();
        mdu_valid = 0;
        #1;
        chk("wb_pend_clr", pend, 32'h0);
        chk("wb_after_stall", {31'b0, stall}, 32'h0);
        rd_a1 = 0;

        // MDU starvation bound
        pipe_we = 1; pipe_a3 = 5'd10; pipe_wd = 32'hA0A0_0001;
        mdu_valid = 1; mdu_a3 = 5'd5; mdu_wd = 32'hBEEF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("starve_ready_%0d", i), {31'b0, mdu_ready}, 32'h0);
            chk($sformatf("starve_a3_%0d", i), {27'b0, grf_a3}, 32'd10);
            chk($sformatf("starve_hold_%0d", i), {31'b0, pipe_hold}, 32'h0);
            step();
        end
        chk("starve_gnt_ready", {31'b0, mdu_ready}, 32'h1);
        chk("starve_gnt_hold", {31'b0, pipe_hold}, 32'h1);
        chk("starve_gnt_a3", {27'b0, grf_a3}, 32'd5);
        chk("starve_gnt_wd", grf_wd, 32'hBEEF);
        chk("starve_gnt_stall", {31'b0, stall}, 32'h1);
        step();
        mdu_valid = 0;
        #1;
        chk("held_pipe_a3", {27'b0, grf_a3}, 32'd10);
        chk("held_pipe_we", {31'b0, grf_we}, 32'h1);
        chk("held_pipe_hold", {31'b0, pipe_hold}, 32'h0);
        chk("held_pipe_wd", grf_wd, 32'hA0A0_0001);
        pipe_we = 0;

        // writes to $0
        step();
        mdu_valid = 1; mdu_a3 = 5'd0; mdu_wd = 32'h55;
        #1;
        chk("mdu_r0_ready", {31'b0, mdu_ready}, 32'h1);
        chk("mdu_r0_we", {31'b0, grf_we}, 32'h0);
        step();
        mdu_valid = 0;
        pipe_we = 1; pipe_a3 = 5'd0; pipe_wd = 32'h77;
        #1;
        chk("pipe_r0_we", {31'b0, grf_we}, 32'h0);
        chk("pipe_r0_wd", grf_wd, 32'h0);
        chk("pipe_r0_hold", {31'b0, pipe_hold}, 32'h0);
        idle();

        // set wins over same-cycle clear on $7
        step();
        iss_valid = 1; iss_long = 1; iss_a3 = 5'd7;
        step();
        chk("pend_7", pend, 32'h0000_0080);
        mdu_valid = 1; mdu_a3 = 5'd7; mdu_wd = 32'h7;
        #1;
        chk("setclr_stall", {31'b0, stall}, 32'h0);
        step();
        idle();
        chk("setclr_pend", pend, 32'h0000_0080);
        mdu_valid = 1; mdu_a3 = 5'd7;
        step();
        idle();
        chk("clr_7", pend, 32'h0);

        // WAW on $9, and stalled issues ignored
        iss_valid = 1; iss_long = 1; iss_a3 = 5'd9;
        step();
        chk("pend_9", pend, 32'h0000_0200);
        #1;
        chk("waw_stall", {31'b0, stall}, 32'h1);
        step();
        chk("waw_pend", pend, 32'h0000_0200);
        iss_a3 = 5'd3; rd_a2 = 5'd9;
        #1;
        chk("raw2_stall", {31'b0, stall}, 32'h1);
        step();
        chk("raw2_pend", pend, 32'h0000_0200);
        rd_a2 = 0; iss_a3 = 5'd0;
        #1;
        chk("r0_iss_stall", {31'b0, stall}, 32'h0);
        step();
        idle();
        chk("r0_iss_pend", pend, 32'h0000_0200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
